sar_adc_model: RTL and testbench
================================

# sar_adc_model

Clocked behavioural successive-approximation ADC that consumes the real-valued analog output of the resistive divider stage and produces an N-bit digital code. It samples `vin` on a start request and holds it. It then resolves one bit per clock, MSB first, against an internal real-valued DAC. It reports the result through a start/busy/done handshake to the downstream digital logic.

## Interface
Parameters:
- `N_BITS`, 8: output code width; number of conversion cycles.
- `VREF`, 5.0 (real): full-scale reference voltage; LSB = `VREF / 2**N_BITS`.

Ports:
- `clk`  input  1  conversion clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `vin`  input  real  analog input, normally the divider's `vout`.
- `start`  input  1  conversion request; sampled on rising edges.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when `dout` is updated.
- `dout`  output  `N_BITS`  last completed conversion code.
- `ovr`  output  1  sampled value was `>= VREF` or `< 0.0`; valid with `dout`.

## Operation
- There are three states: IDLE, SAMPLE and CONVERT.
- **IDLE** (`busy`=0):
  - An edge with `start`=1 moves the block to SAMPLE.
  - An edge with `start`=0 keeps it in IDLE.
- **SAMPLE** (`busy`=1), on the next edge:
  - `vhold <= vin`.
  - Trial code = `1 << (N_BITS-1)`.
  - Bit index = `N_BITS-1`.
  - Go to CONVERT.
- **CONVERT** (`busy`=1), on each edge:
  - Compare `vhold >= trial_code * LSB` in real arithmetic. True keeps the current trial bit; false clears it.
  - Set the next lower bit as the new trial bit and decrement the bit index.
  - On the edge that decides bit 0:
    - `dout <= final code`.
    - `done <= 1`.
    - `ovr <= (vhold >= VREF) || (vhold < 0.0)`.
    - Return to IDLE.
- **Result rule:** code = floor(`vhold`/LSB), saturated to [0, 2^N_BITS−1].
  - Exact LSB multiples round up, because the comparison is `>=`.
  - Negative inputs give 0.
  - Inputs `>= VREF` give all-ones.
- **Start handling:**
  - `start` is ignored while `busy`=1; there is no queuing.
  - A new conversion may be requested in the cycle where `done`=1 (back-to-back operation).
- **Input isolation:** `vin` changes after the SAMPLE edge do not affect the result.
- **Output hold:** `dout` and `ovr` keep their value until the next completion.
- **Reset:**
  - When `rst_n`=0, immediately:
    - state = IDLE
    - `busy`=0, `done`=0, `ovr`=0
    - `dout`='0
    - `vhold`=0.0
    - trial code and bit index = 0
  - Reset mid-conversion aborts with no `done` pulse.

## Timing
- The start edge is E0 (`start`=1 seen in IDLE).
- `busy` is high from E0 until the edge that decides bit 0.
- The sample is taken at E1.
- Bit k (MSB = `N_BITS-1`) is decided at edge E(N_BITS+1−k).
- `dout`, `ovr` and the rising `done` all update at E(N_BITS+1). `busy` falls on that same edge.
- `done` falls at E(N_BITS+2), unless it is re-asserted by another completion (not possible that soon).
- Latency, start edge to result edge: `N_BITS`+1 clocks. Minimum conversion period: `N_BITS`+2 clocks.
- `busy`, `done`, `dout` and `ovr` are registered outputs with no combinational path from `start` or `vin`.

## Structure
- Package `adc_pkg` holds:
  - the state enum `sar_state_t` (IDLE, SAMPLE, CONVERT);
  - the function `code_to_volts(code, n_bits, vref)` returning a real.
- The same function is used by the bench to build expected values.
- Sub-module `sar_dac`: combinational real-valued DAC.
  - Inputs: trial code.
  - Output: `vdac` (real), computed via `code_to_volts`.
  - It is instantiated once. The top holds the FSM, the sample-and-hold and the comparator.

## Test plan
All scenarios use `VREF`=5.0, `N_BITS`=8, LSB=0.01953125.
- `vin`=2.5, pulse `start` → `dout`=128, `ovr`=0, `done` for exactly one cycle, 9 clocks after the start edge.
- `vin`=1.0 → `dout`=51. `vin`=5.0 → `dout`=255, `ovr`=1. `vin`=−0.3 → `dout`=0, `ovr`=1.
- `vin`=3.0, start, then `vin` changed to 0.5 two clocks later → `dout`=153, the held value wins.
- `start` held high continuously with `vin`=4.0 → back-to-back results of 204 every 10 clocks; `start` pulses during `busy` are ignored.
- `rst_n` asserted during the 4th CONVERT cycle → all outputs go to 0 immediately with no `done`; a new conversion after release gives the correct code.
- Random sweep over 200 values of `vin` in [0, 5) → `dout` == floor(`vin`/LSB) for each.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the behavioural SAR ADC and its DAC.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT
  } sar_state_t;

  // Ideal DAC transfer: code * VREF / 2**n_bits.
  function automatic real code_to_volts(input longint unsigned code,
                                        input int unsigned     n_bits,
                                        input real             vref);
    return (real'(code) * vref) / real'(64'(1) << n_bits);
  endfunction

endpackage

// File: rtl/sar_dac.sv
// Combinational real-valued DAC producing the trial voltage for the comparator.
module sar_dac
  import adc_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter real         VREF   = 5.0
) (
  input  logic [N_BITS-1:0] code,
  output real               vdac
);

  always_comb begin
    vdac = code_to_volts(64'(code), N_BITS, VREF);
  end

endmodule

// File: rtl/sar_adc_model.sv
// Behavioural SAR ADC: sample-and-hold, MSB-first bit resolution against
// sar_dac, and a start/busy/done handshake with registered outputs.
module sar_adc_model
  import adc_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter real         VREF   = 5.0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  real               vin,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] dout,
  output logic              ovr
);

  localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [N_BITS-1:0] MSB_CODE = N_BITS'(1) << (N_BITS - 1);

  sar_state_t        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [N_BITS-1:0] dout_q, dout_d;
  logic [N_BITS-1:0] trial_q, trial_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  real               vhold_q, vhold_d;

  real               vdac;
  logic [N_BITS-1:0] bit_mask;
  logic [N_BITS-1:0] code_res;

  sar_dac #(
    .N_BITS(N_BITS),
    .VREF  (VREF)
  ) u_dac (
    .code(trial_q),
    .vdac(vdac)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    dout_d   = dout_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    vhold_d  = vhold_q;
    bit_mask = N_BITS'(1) << idx_q;
    // Comparator: keep the trial bit when the held sample reaches the DAC level.
    code_res = (vhold_q >= vdac) ? trial_q : (trial_q & ~bit_mask);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          busy_d  = 1'b1;
        end
      end
      SAMPLE: begin
        vhold_d = vin;
        trial_d = MSB_CODE;
        idx_d   = IDX_W'(N_BITS - 1);
        state_d = CONVERT;
      end
      CONVERT: begin
        if (idx_q == '0) begin
          dout_d  = code_res;
          done_d  = 1'b1;
          ovr_d   = (vhold_q >= VREF) || (vhold_q < 0.0);
          busy_d  = 1'b0;
          trial_d = '0;
          state_d = IDLE;
        end else begin
          trial_d = code_res | (bit_mask >> 1);
          idx_d   = idx_q - IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
      trial_q <= '0;
      idx_q   <= '0;
      vhold_q <= 0.0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
      trial_q <= trial_d;
      idx_q   <= idx_d;
      vhold_q <= vhold_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_sar_adc_model.sv
// Directed and table-driven checks for sar_adc_model (N_BITS=8, VREF=5.0).
module tb_sar_adc_model;
  import adc_pkg::*;

  logic       clk;
  logic       rst_n;
  real        vin;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       ovr;

  int n_checks = 0;
  int n_fail   = 0;

  sar_adc_model #(
    .N_BITS(8),
    .VREF  (5.0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vin  (vin),
    .start(start),
    .busy (busy),
    .done (done),
    .dout (dout),
    .ovr  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    real   vin;
    int    exp_dout;
    bit    exp_ovr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One conversion from an idle DUT; optionally changes vin after edge chg.
  task automatic run_conv(input string nm, input real v, input int exp_d,
                          input bit exp_o, input real v2, input int chg);
    int edges;
    @(negedge clk);
    vin   = v;
    start = 1'b1;
    @(posedge clk); #1;
    check({nm, "_busy_e0"}, longint'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (chg != 0 && edges == chg) vin = v2;
      if (done) break;
    end
    check({nm, "_latency"}, edges, 9);
    check({nm, "_dout"}, longint'(dout), exp_d);
    check({nm, "_ovr"}, longint'(ovr), longint'(exp_o));
    check({nm, "_busy_end"}, longint'(busy), 0);
    @(posedge clk); #1;
    check({nm, "_done_fall"}, longint'(done), 0);
    check({nm, "_dout_hold"}, longint'(dout), exp_d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   last;
    int   n_done;
    int   k;
    real  lsb;
    real  frac;
    real  v;

    vecs[0] = '{"mid",     2.5,        128, 1'b0};
    vecs[1] = '{"one",     1.0,        51,  1'b0};
    vecs[2] = '{"vref",    5.0,        255, 1'b1};
    vecs[3] = '{"neg",     -0.3,       0,   1'b1};
    vecs[4] = '{"zero",    0.0,        0,   1'b0};
    vecs[5] = '{"top",     4.99,       255, 1'b0};
    vecs[6] = '{"lsb",     0.01953125, 1,   1'b0};
    vecs[7] = '{"sublsb",  0.0195,     0,   1'b0};
    vecs[8] = '{"below",   2.49,       127, 1'b0};
    vecs[9] = '{"huge",    7.0,        255, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    vin   = 0.0;
    #2;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_dout", longint'(dout), 0);
    check("rst_ovr",  longint'(ovr),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low must not begin a conversion.
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", longint'(busy), 0);

    for (int i = 0; i < 10; i++)
      run_conv(vecs[i].name, vecs[i].vin, vecs[i].exp_dout, vecs[i].exp_ovr, 0.0, 0);

    // Held sample must win over a later vin change.
    run_conv("hold", 3.0, 153, 1'b0, 0.5, 2);

    // start held high: back-to-back results every 10 clocks.
    @(negedge clk);
    vin    = 4.0;
    start  = 1'b1;
    cyc    = 0;
    last   = -1;
    n_done = 0;
    while (n_done < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        check("b2b_dout", longint'(dout), 204);
        if (last < 0) check("b2b_first", cyc, 10);
        else          check("b2b_period", cyc - last, 10);
        last = cyc;
        n_done++;
      end
    end
    check("b2b_count", n_done, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("b2b_stop_busy", longint'(busy), 0);

    // Reset during the 4th CONVERT cycle aborts without a done pulse.
    @(negedge clk);
    vin   = 2.5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("abort_busy_pre", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_dout", longint'(dout), 0);
    check("abort_ovr",  longint'(ovr),  0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", longint'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", longint'(done), 0);
    end
    run_conv("post_rst", 1.0, 51, 1'b0, 0.0, 0);

    // Sweep: vin strictly inside code k's bin must convert to k.
    lsb = code_to_volts(1, 8, 5.0);
    for (int i = 0; i < 200; i++) begin
      k    = int'($urandom_range(0, 255));
      frac = real'($urandom_range(5, 95)) / 100.0;
      v    = code_to_volts(longint'(k), 8, 5.0) + frac * lsb;
      run_conv("sweep", v, k, 1'b0, 0.0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
